// File: rtl/ifetch_unit.sv
// Instruction fetch: owns the PC, issues reads to a 1-cycle synchronous ROM and
// buffers returned words in a 2-entry skid FIFO feeding decode over valid/ready.
module ifetch_unit #(
  parameter int          AWIDTH   = 12,
  parameter int          DWIDTH   = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_in,
  output logic              rom_en,
  output logic [AWIDTH-1:0] rom_addr,
  input  logic [DWIDTH-1:0] rom_data,
  output logic [DWIDTH-1:0] inst,
  output logic [AWIDTH-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [AWIDTH-1:0] redirect_pc
);

  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [AWIDTH-1:0] inflight_pc_q;
  logic              inflight_q, inflight_d;
  logic [1:0]        count_q, count_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [DWIDTH-1:0] word_q [2];
  logic [AWIDTH-1:0] epc_q  [2];

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occupancy;

  assign inst_valid = (count_q != 2'd0);
  assign inst       = inst_valid ? word_q[rd_ptr_q] : '0;
  assign inst_pc    = inst_valid ? epc_q[rd_ptr_q]  : '0;

  assign pop  = inst_valid & inst_ready;
  // A redirect kills the returning read so stale words never reach decode.
  assign push = inflight_q & ~redirect;

  // Credit check: FIFO entries plus the read in flight, less this cycle's pop,
  // must leave room for the word this issue will return.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q};
  assign issue     = en_in & ~redirect & ~rst & (occupancy < (3'd2 + {2'b00, pop}));

  assign rom_en   = issue;
  assign rom_addr = pc_q;

  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect) begin
      pc_d       = redirect_pc;
      inflight_d = 1'b0;
      count_d    = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
    end else begin
      inflight_d = issue;
      if (issue) pc_d = pc_q + 1'b1;
      if (push)  wr_ptr_d = ~wr_ptr_q;
      if (pop)   rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= AWIDTH'(RESET_PC);
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Payload storage is qualified by count/inflight, so it needs no reset.
  always_ff @(posedge clk) begin
    if (issue) inflight_pc_q <= pc_q;
    if (push) begin
      word_q[wr_ptr_q] <= rom_data;
      epc_q[wr_ptr_q]  <= inflight_pc_q;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a behavioural 1-cycle synchronous ROM.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_in;
  logic        rom_en;
  logic [11:0] rom_addr;
  logic [15:0] rom_data;
  logic [15:0] inst;
  logic [11:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect;
  logic [11:0] redirect_pc;

  int compared   = 0;
  int mismatched = 0;

  ifetch_unit #(.AWIDTH(12), .DWIDTH(16), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .en_in(en_in),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // ROM contents: A000,B100,C200,D300 at 0..3, otherwise {4'hE, address}.
  function automatic logic [15:0] rv(input logic [11:0] a);
    case (a)
      12'd0:   rv = 16'hA000;
      12'd1:   rv = 16'hB100;
      12'd2:   rv = 16'hC200;
      12'd3:   rv = 16'hD300;
      default: rv = {4'hE, a};
    endcase
  endfunction

  always @(posedge clk) if (rom_en) rom_data <= rv(rom_addr);

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en_in = 1'b1; inst_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    cyc(); cyc();
    compared++;
    if ({rom_en, rom_addr, inst_valid, inst, inst_pc} !== {1'b0, 12'h000, 1'b0, 16'h0000, 12'h000}) begin
      mismatched++;
      $display("FAIL reset_state: got en=%0b addr=%h v=%0b inst=%h pc=%h, want 0 000 0 0000 000",
               rom_en, rom_addr, inst_valid, inst, inst_pc);
    end
  endtask

  task automatic test_stream();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 6; k++) begin
      compared++;
      if ({rom_en, rom_addr} !== {1'b1, 12'(k)}) begin
        mismatched++;
        $display("FAIL stream_issue[%0d]: got en=%0b addr=%h, want 1 %h", k, rom_en, rom_addr, 12'(k));
      end
      compared++;
      if (k < 2) begin
        if (inst_valid !== 1'b0) begin
          mismatched++;
          $display("FAIL stream_latency[%0d]: got valid=%0b, want 0", k, inst_valid);
        end
      end else if ({inst_valid, inst_pc, inst} !== {1'b1, 12'(k - 2), rv(12'(k - 2))}) begin
        mismatched++;
        $display("FAIL stream_out[%0d]: got v=%0b pc=%h inst=%h, want 1 %h %h",
                 k, inst_valid, inst_pc, inst, 12'(k - 2), rv(12'(k - 2)));
      end
      cyc();
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] exp_pc;
    inst_ready = 1'b0;
    #1;
    for (int b = 0; b < 5; b++) begin
      compared++;
      if ({rom_en, inst_valid, inst_pc, inst} !== {1'b0, 1'b1, 12'h004, 16'hE004}) begin
        mismatched++;
        $display("FAIL bp_hold[%0d]: got en=%0b v=%0b pc=%h inst=%h, want 0 1 004 E004",
                 b, rom_en, inst_valid, inst_pc, inst);
      end
      cyc();
    end
    inst_ready = 1'b1;
    #1;
    compared++;
    if ({rom_en, rom_addr} !== {1'b1, 12'h006}) begin
      mismatched++;
      $display("FAIL bp_resume_issue: got en=%0b addr=%h, want 1 006", rom_en, rom_addr);
    end
    exp_pc = 12'h004;
    for (int i = 0; i < 8; i++) begin
      compared++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, exp_pc, rv(exp_pc)}) begin
        mismatched++;
        $display("FAIL bp_drain[%0d]: got v=%0b pc=%h inst=%h, want 1 %h %h",
                 i, inst_valid, inst_pc, inst, exp_pc, rv(exp_pc));
      end
      exp_pc++;
      cyc();
    end
  endtask

  task automatic test_redirect();
    redirect = 1'b1; redirect_pc = 12'h100;
    #1;
    compared++;
    if (rom_en !== 1'b0) begin
      mismatched++;
      $display("FAIL redir_no_issue: got en=%0b, want 0", rom_en);
    end
    cyc();
    redirect = 1'b0;
    #1;
    compared++;
    if ({inst_valid, rom_en, rom_addr} !== {1'b0, 1'b1, 12'h100}) begin
      mismatched++;
      $display("FAIL redir_r1: got v=%0b en=%0b addr=%h, want 0 1 100", inst_valid, rom_en, rom_addr);
    end
    cyc();
    compared++;
    if ({inst_valid, rom_en, rom_addr} !== {1'b0, 1'b1, 12'h101}) begin
      mismatched++;
      $display("FAIL redir_r2: got v=%0b en=%0b addr=%h, want 0 1 101", inst_valid, rom_en, rom_addr);
    end
    cyc();
    compared++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 12'h100, 16'hE100}) begin
      mismatched++;
      $display("FAIL redir_r3: got v=%0b pc=%h inst=%h, want 1 100 E100", inst_valid, inst_pc, inst);
    end
  endtask

  task automatic test_wrap();
    logic [11:0] pcs [4];
    logic [15:0] ws  [4];
    pcs = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    ws  = '{16'hEFFE, 16'hEFFF, 16'hA000, 16'hB100};
    redirect = 1'b1; redirect_pc = 12'hFFE;
    cyc();
    redirect = 1'b0;
    cyc(); cyc();
    for (int i = 0; i < 4; i++) begin
      compared++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, pcs[i], ws[i]}) begin
        mismatched++;
        $display("FAIL wrap[%0d]: got v=%0b pc=%h inst=%h, want 1 %h %h",
                 i, inst_valid, inst_pc, inst, pcs[i], ws[i]);
      end
      cyc();
    end
  endtask

  task automatic test_enable();
    redirect = 1'b1; redirect_pc = 12'h002;
    cyc();
    redirect = 1'b0;
    cyc(); cyc();
    compared++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 12'h002, 16'hC200}) begin
      mismatched++;
      $display("FAIL en_pre: got v=%0b pc=%h inst=%h, want 1 002 C200", inst_valid, inst_pc, inst);
    end
    cyc();
    en_in = 1'b0;
    #1;
    compared++;
    if ({rom_en, inst_valid, inst_pc, inst} !== {1'b0, 1'b1, 12'h003, 16'hD300}) begin
      mismatched++;
      $display("FAIL en_off0: got en=%0b v=%0b pc=%h inst=%h, want 0 1 003 D300", rom_en, inst_valid, inst_pc, inst);
    end
    cyc();
    compared++;
    if ({rom_en, inst_valid, inst_pc, inst} !== {1'b0, 1'b1, 12'h004, 16'hE004}) begin
      mismatched++;
      $display("FAIL en_off1: got en=%0b v=%0b pc=%h inst=%h, want 0 1 004 E004", rom_en, inst_valid, inst_pc, inst);
    end
    for (int i = 2; i < 4; i++) begin
      cyc();
      compared++;
      if ({rom_en, inst_valid} !== 2'b00) begin
        mismatched++;
        $display("FAIL en_off%0d: got en=%0b v=%0b, want 0 0", i, rom_en, inst_valid);
      end
    end
    cyc();
    en_in = 1'b1;
    #1;
    compared++;
    if ({rom_en, rom_addr} !== {1'b1, 12'h005}) begin
      mismatched++;
      $display("FAIL en_resume: got en=%0b addr=%h, want 1 005", rom_en, rom_addr);
    end
    cyc(); cyc();
    compared++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 12'h005, 16'hE005}) begin
      mismatched++;
      $display("FAIL en_resume_out: got v=%0b pc=%h inst=%h, want 1 005 E005", inst_valid, inst_pc, inst);
    end
  endtask

  task automatic test_midreset();
    inst_ready = 1'b0;
    cyc(); cyc(); cyc();
    compared++;
    if ({rom_en, inst_valid} !== 2'b01) begin
      mismatched++;
      $display("FAIL mrst_full: got en=%0b v=%0b, want 0 1", rom_en, inst_valid);
    end
    #1;
    rst = 1'b1;
    #1;
    compared++;
    if ({rom_en, rom_addr, inst_valid, inst, inst_pc} !== {1'b0, 12'h000, 1'b0, 16'h0000, 12'h000}) begin
      mismatched++;
      $display("FAIL mrst_async: got en=%0b addr=%h v=%0b inst=%h pc=%h, want 0 000 0 0000 000",
               rom_en, rom_addr, inst_valid, inst, inst_pc);
    end
    cyc();
    rst = 1'b0; inst_ready = 1'b1;
    #1;
    compared++;
    if ({rom_en, rom_addr, inst_valid} !== {1'b1, 12'h000, 1'b0}) begin
      mismatched++;
      $display("FAIL mrst_restart0: got en=%0b addr=%h v=%0b, want 1 000 0", rom_en, rom_addr, inst_valid);
    end
    cyc();
    compared++;
    if ({rom_en, rom_addr, inst_valid} !== {1'b1, 12'h001, 1'b0}) begin
      mismatched++;
      $display("FAIL mrst_restart1: got en=%0b addr=%h v=%0b, want 1 001 0", rom_en, rom_addr, inst_valid);
    end
    cyc();
    compared++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 12'h000, 16'hA000}) begin
      mismatched++;
      $display("FAIL mrst_out0: got v=%0b pc=%h inst=%h, want 1 000 A000", inst_valid, inst_pc, inst);
    end
    cyc();
    compared++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 12'h001, 16'hB100}) begin
      mismatched++;
      $display("FAIL mrst_out1: got v=%0b pc=%h inst=%h, want 1 001 B100", inst_valid, inst_pc, inst);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_enable();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
